// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP transmitter.
// - state_t  : frame-generation state machine encoding
// - CNT_W    : width of the cycle and line counters
// - cnt_t    : counter type
// - HI_FIRST : byte order on the bus (1 = high byte of each pixel goes out first)
package dvp_pkg;

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam bit HI_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VFP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VBP    = 3'd5
    } state_t;

    // Byte that leaves first / second for a given pixel.
    function automatic logic [7:0] first_byte(input logic [15:0] pix);
        return HI_FIRST ? pix[15:8] : pix[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] pix);
        return HI_FIRST ? pix[7:0] : pix[15:8];
    endfunction

endpackage

// File: rtl/dvp_tx.sv
// DVP camera-bus transmitter: turns a valid/ready stream of RGB565 pixels into
// vsync / href / 8-bit data, two byte cycles per pixel, high byte first.
// Ports:
//   pclk, rst        : byte clock, synchronous active-high reset
//   enable           : start a frame (sampled only in IDLE)
//   s_data, s_valid  : input pixel stream
//   s_ready          : combinational, high in ACTIVE on the first byte slot
//   dvp_vsync        : frame sync (registered)
//   dvp_href         : line valid (registered)
//   dvp_data         : byte bus, 0x00 while href is low (registered)
//   frame_done       : one-cycle pulse as the frame ends (registered)
//   underrun         : one-cycle pulse when a pixel slot found s_valid low
module dvp_tx
    import dvp_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int VSYNC_CYC  = 16,
    parameter int VFP_CYC    = 32,
    parameter int HBLANK_CYC = 16,
    parameter int VBP_CYC    = 32
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underrun
);

    localparam cnt_t VSYNC_LAST  = cnt_t'(VSYNC_CYC - 1);
    localparam cnt_t VFP_LAST    = cnt_t'(VFP_CYC - 1);
    localparam cnt_t ACTIVE_LAST = cnt_t'(2 * IMG_WIDTH - 1);
    localparam cnt_t HBLANK_LAST = cnt_t'(HBLANK_CYC - 1);
    localparam cnt_t VBP_LAST    = cnt_t'(VBP_CYC - 1);
    localparam cnt_t LINE_LAST   = cnt_t'(IMG_HEIGHT - 1);

    // FSM and counters
    state_t      state_q, state_d;
    cnt_t        cyc_cnt_q, cyc_cnt_d;
    cnt_t        line_cnt_q, line_cnt_d;
    logic        phase_q, phase_d;
    logic [15:0] pix_q, pix_d;

    // Output register stage
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        under_q, under_d;

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q + cnt_t'(1);
        line_cnt_d = line_cnt_q;
        phase_d    = 1'b0;
        pix_d      = pix_q;
        s_ready    = 1'b0;
        vsync_d    = 1'b0;
        href_d     = 1'b0;
        data_d     = 8'h00;
        done_d     = 1'b0;
        under_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cyc_cnt_d  = '0;
                line_cnt_d = '0;
                if (enable) begin
                    state_d = ST_VSYNC;
                end
            end

            ST_VSYNC: begin
                vsync_d = 1'b1;
                if (cyc_cnt_q == VSYNC_LAST) begin
                    state_d   = ST_VFP;
                    cyc_cnt_d = '0;
                end
            end

            ST_VFP: begin
                if (cyc_cnt_q == VFP_LAST) begin
                    state_d   = ST_ACTIVE;
                    cyc_cnt_d = '0;
                end
            end

            ST_ACTIVE: begin
                href_d  = 1'b1;
                phase_d = ~phase_q;
                if (!phase_q) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        pix_d  = s_data;
                        data_d = first_byte(s_data);
                    end else begin
                        // Starved slot: timing carries on, a zero pixel goes out.
                        pix_d   = 16'h0000;
                        under_d = 1'b1;
                    end
                end else begin
                    data_d = second_byte(pix_q);
                end

                if (cyc_cnt_q == ACTIVE_LAST) begin
                    cyc_cnt_d = '0;
                    phase_d   = 1'b0;
                    if (line_cnt_q == LINE_LAST) begin
                        state_d    = ST_VBP;
                        line_cnt_d = '0;
                    end else begin
                        state_d    = ST_HBLANK;
                        line_cnt_d = line_cnt_q + cnt_t'(1);
                    end
                end
            end

            ST_HBLANK: begin
                if (cyc_cnt_q == HBLANK_LAST) begin
                    state_d   = ST_ACTIVE;
                    cyc_cnt_d = '0;
                end
            end

            ST_VBP: begin
                if (cyc_cnt_q == VBP_LAST) begin
                    state_d   = ST_IDLE;
                    cyc_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cyc_cnt_d = '0;
            end
        endcase
    end

    // FSM state and counters
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cyc_cnt_q  <= '0;
            line_cnt_q <= '0;
            phase_q    <= 1'b0;
            pix_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            line_cnt_q <= line_cnt_d;
            phase_q    <= phase_d;
            pix_q      <= pix_d;
        end
    end

    // Registered bus outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

    assign dvp_vsync  = vsync_q;
    assign dvp_href   = href_q;
    assign dvp_data   = data_q;
    assign frame_done = done_q;
    assign underrun   = under_q;

endmodule

// File: tb/tb_dvp_tx.sv
module tb_dvp_tx;

    localparam int W      = 4;
    localparam int H      = 2;
    localparam int VS     = 3;
    localparam int VFP    = 2;
    localparam int HB     = 3;
    localparam int VBP    = 2;
    localparam int PERIOD = 27; // 1 + 3 + 2 + 2*8 + 1*3 + 2

    logic        pclk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_done;
    logic        underrun;

    dvp_tx #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .VSYNC_CYC (VS),
        .VFP_CYC   (VFP),
        .HBLANK_CYC(HB),
        .VBP_CYC   (VBP)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .enable    (enable),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dvp_vsync (dvp_vsync),
        .dvp_href  (dvp_href),
        .dvp_data  (dvp_data),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 pclk = ~pclk;

    // Hand-computed pixel vectors and their bus bytes.
    typedef struct {
        logic [15:0] pix;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vecs [8];
    initial begin
        vecs[0] = '{16'h1234, 8'h12, 8'h34};
        vecs[1] = '{16'h5678, 8'h56, 8'h78};
        vecs[2] = '{16'h9ABC, 8'h9A, 8'hBC};
        vecs[3] = '{16'hDEF0, 8'hDE, 8'hF0};
        vecs[4] = '{16'h0F1E, 8'h0F, 8'h1E};
        vecs[5] = '{16'h2D3C, 8'h2D, 8'h3C};
        vecs[6] = '{16'h4B5A, 8'h4B, 8'h5A};
        vecs[7] = '{16'h6978, 8'h69, 8'h78};
    end

    typedef struct {
        logic [7:0] data;
        logic       und;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int hs_idx      = 0;
    int starve_slot = -1;
    int byte_no     = 0;

    // Monitor state
    int cyc_ctr        = 0;
    int done_cnt       = 0;
    int under_cnt      = 0;
    int vs_rise_cnt    = 0;
    int last_rise      = -1;
    int last_period    = 0;
    int vs_len         = 0;
    int href_len       = 0;
    int low_len        = 0;
    int lines_in_frame = 0;
    logic vs_prev      = 1'b0;
    logic href_prev    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source: offers a pixel every cycle; when the DUT takes one, the bytes it
    // must produce go into the scoreboard.
    initial begin
        s_valid = 1'b0;
        s_data  = 16'h0000;
        forever begin
            @(negedge pclk);
            if (rst) begin
                s_valid = 1'b0;
                s_data  = 16'h0000;
            end else begin
                if (hs_idx == starve_slot) begin
                    s_valid = 1'b0;
                    s_data  = 16'hFFFF;
                    if (s_ready) begin
                        exp_q.push_back('{8'h00, 1'b1});
                        exp_q.push_back('{8'h00, 1'b0});
                        hs_idx++;
                    end
                end else begin
                    s_valid = 1'b1;
                    s_data  = vecs[hs_idx % 8].pix;
                    if (s_ready) begin
                        exp_q.push_back('{vecs[hs_idx % 8].hi, 1'b0});
                        exp_q.push_back('{vecs[hs_idx % 8].lo, 1'b0});
                        hs_idx++;
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pops and bus-timing checks.
    always @(negedge pclk) begin
        cyc_ctr++;
        if (rst) begin
            vs_prev   = 1'b0;
            href_prev = 1'b0;
            vs_len    = 0;
            href_len  = 0;
            low_len   = 0;
            last_rise = -1;
        end else begin
            check("vsync_href_overlap", int'(dvp_vsync & dvp_href), 0);

            if (dvp_vsync) begin
                if (!vs_prev) begin
                    vs_rise_cnt++;
                    lines_in_frame = 0;
                    if (last_rise >= 0) last_period = cyc_ctr - last_rise;
                    last_rise = cyc_ctr;
                end
                vs_len++;
            end else if (vs_prev) begin
                check("vsync_width", vs_len, VS);
                vs_len = 0;
            end

            if (dvp_href) begin
                if (!href_prev) begin
                    if (lines_in_frame > 0) check("hblank_width", low_len, HB);
                    lines_in_frame++;
                    href_len = 0;
                end
                href_len++;
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty_on_href", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("byte %0d: data=%02h exp=%02h underrun=%0b", byte_no, dvp_data, e.data, underrun);
                    byte_no++;
                    check("dvp_data", int'(dvp_data), int'(e.data));
                    check("underrun_slot", int'(underrun), int'(e.und));
                end
            end else begin
                if (href_prev) begin
                    check("href_width", href_len, 2 * W);
                    low_len = 0;
                end
                low_len++;
                check("data_idle_zero", int'(dvp_data), 0);
                check("underrun_idle", int'(underrun), 0);
            end

            if (frame_done) begin
                done_cnt++;
                check("lines_per_frame", lines_in_frame, H);
            end
            if (underrun) under_cnt++;

            vs_prev   = dvp_vsync;
            href_prev = dvp_href;
        end
    end

    task automatic wait_done(input int pulses, input int limit, input string name);
        int seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge pclk);
            #1;
            if (frame_done) seen++;
            if (seen >= pulses) return;
        end
        check({"timeout_", name}, 0, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vsync"}, int'(dvp_vsync), 0);
        check({tag, "_href"}, int'(dvp_href), 0);
        check({tag, "_data"}, int'(dvp_data), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_s_ready"}, int'(s_ready), 0);
    endtask

    int d0, h0, u0, v0;
    bit hit;

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Two back-to-back frames, s_valid always high.
        d0 = done_cnt; h0 = hs_idx; u0 = under_cnt; v0 = vs_rise_cnt;
        enable = 1'b1;
        wait_done(2, 200, "two_frames");
        enable = 1'b0;
        repeat (40) @(posedge pclk);
        #1;
        check("frames_done", done_cnt - d0, 2);
        check("handshakes_2_frames", hs_idx - h0, 2 * W * H);
        check("frame_period", last_period, PERIOD);
        check("no_underrun", under_cnt - u0, 0);
        check("vsync_count_idle", vs_rise_cnt - v0, 2);
        check("queue_drained_a", exp_q.size(), 0);

        // Starve pixel index 2 of line 0.
        d0 = done_cnt; h0 = hs_idx; u0 = under_cnt;
        starve_slot = hs_idx + 2;
        enable = 1'b1;
        wait_done(1, 100, "underrun_frame");
        enable = 1'b0;
        repeat (10) @(posedge pclk);
        #1;
        check("underrun_pulses", under_cnt - u0, 1);
        check("underrun_frame_done", done_cnt - d0, 1);
        check("handshakes_with_underrun", hs_idx - h0, W * H);
        check("queue_drained_b", exp_q.size(), 0);

        // Drop enable during line 1: frame must still complete.
        d0 = done_cnt; v0 = vs_rise_cnt;
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge pclk);
            #1;
            if (lines_in_frame == 2 && dvp_href) hit = 1'b1;
        end
        check("reached_line1", int'(hit), 1);
        enable = 1'b0;
        wait_done(1, 100, "enable_drop");
        repeat (30) @(posedge pclk);
        #1;
        check("drop_frame_done", done_cnt - d0, 1);
        check("drop_single_vsync", vs_rise_cnt - v0, 1);
        check("drop_idle_vsync", int'(dvp_vsync), 0);

        // Reset in the middle of a line.
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge pclk);
            #1;
            if (dvp_href) hit = 1'b1;
        end
        check("reached_active", int'(hit), 1);
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge pclk);
        #1;
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        d0 = done_cnt; v0 = vs_rise_cnt;
        wait_done(1, 100, "after_reset");
        enable = 1'b0;
        repeat (10) @(posedge pclk);
        #1;
        check("reset_frame_done", done_cnt - d0, 1);
        check("reset_vsync_count", vs_rise_cnt - v0, 1);
        check("queue_drained_c", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dvp_tx.md
# dvp_tx

- Drives a DVP-style camera bus (`vsync`, `href`, 8-bit data) from a stream of 16-bit RGB565 pixels.
- Acts as the transmit end of the OV5640 capture interface: a camera emulator for loopback/bench use, and a source for downstream DVP-input devices.
- Each pixel goes out as two bytes, high byte first, so the capture side rebuilds `{first, second}` into the original 16-bit word.
- Frame geometry and blanking are set by parameters; pixels are pulled through a valid/ready handshake.

## Interface
- `IMG_WIDTH`, 640: pixels per line; each line is 2*IMG_WIDTH byte cycles.
- `IMG_HEIGHT`, 480: lines per frame.
- `VSYNC_CYC`, 16: cycles `dvp_vsync` is high.
- `VFP_CYC`, 32: cycles from `dvp_vsync` falling to the first `href`.
- `HBLANK_CYC`, 16: `href`-low cycles between lines (≥1).
- `VBP_CYC`, 32: cycles after the last line before the frame ends.
- `pclk` in 1: pixel/byte clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start/continue frame generation; sampled only in IDLE.
- `s_data` in 16: RGB565 pixel.
- `s_valid` in 1: `s_data` valid.
- `s_ready` out 1: pixel accepted this cycle when `s_valid` is also high.
- `dvp_vsync` out 1: frame sync, active high.
- `dvp_href` out 1: line valid.
- `dvp_data` out 8: byte bus.
- `frame_done` out 1: one-cycle pulse at the end of the frame.
- `underrun` out 1: one-cycle pulse when a pixel was needed and `s_valid` was low.

## Operation
- Decided: one clock; reset is synchronous and active-high (`pclk`, `rst`).
- States:
  - IDLE → VSYNC when `enable`=1.
  - VSYNC (VSYNC_CYC cycles) → VFP.
  - VFP (VFP_CYC cycles) → ACTIVE.
  - ACTIVE (2*IMG_WIDTH cycles) → HBLANK, or → VBP after line IMG_HEIGHT-1.
  - HBLANK (HBLANK_CYC cycles) → ACTIVE.
  - VBP (VBP_CYC cycles) → IDLE, pulsing `frame_done`.
- Frame-to-frame: if `enable` is still 1 on the IDLE cycle, the next frame starts with one IDLE cycle between frames.
- Deasserting `enable` mid-frame: the current frame completes; no truncation.
- Counters:
  - `cyc_cnt` (16-bit) counts within the current state.
  - `line_cnt` (16-bit) counts lines 0..IMG_HEIGHT-1.
  - `phase` (1-bit) selects the byte; cleared outside ACTIVE.
- In ACTIVE, phase 0:
  - `s_ready`=1 (combinational from state and phase).
  - If `s_valid`, latch the pixel and drive `dvp_data`=`s_data[15:8]`.
  - Else drive `dvp_data`=0x00, hold pixel 0x0000 and pulse `underrun`.
  - Underrun never stalls timing; a DVP source cannot stall.
- In ACTIVE, phase 1: `dvp_data`=low byte of the held pixel; `s_ready`=0.
- `s_ready`=0 outside ACTIVE phase 0. Exactly IMG_WIDTH*IMG_HEIGHT handshakes per frame, counting underrun slots.
- `dvp_data`=0x00 whenever `dvp_href`=0.
- Reset (any state, including mid-line): next cycle is IDLE; all counters 0; every output 0.

## Timing
- `dvp_vsync`, `dvp_href`, `dvp_data`, `frame_done` and `underrun` are registered; `s_ready` is combinational.
- A pixel accepted at edge N: high byte on `dvp_data` after edge N, low byte after edge N+1, with `dvp_href` high for both.
- `dvp_href` is high exactly 2*IMG_WIDTH consecutive cycles per line and low exactly HBLANK_CYC cycles between lines.
- `dvp_vsync` and `dvp_href` are never high together.
- Frame period = 1 + VSYNC_CYC + VFP_CYC + IMG_HEIGHT*2*IMG_WIDTH + (IMG_HEIGHT-1)*HBLANK_CYC + VBP_CYC cycles.

## Structure
- Shared package `dvp_pkg`:
  - state enum (IDLE, VSYNC, VFP, ACTIVE, HBLANK, VBP);
  - byte-order constant HI_FIRST=1;
  - 16-bit counter width constant.
- Single flat module; no sub-module needed. Counter and FSM sit in one sequential process; the output register stage in a second.

## Test plan
- IMG_WIDTH=4, IMG_HEIGHT=2, HBLANK_CYC=3 with `s_valid` always 1 and pixels 0x1234, 0x5678, … → `dvp_data` 0x12, 0x34, 0x56, 0x78, …; `href` high 8 cycles, low 3, high 8; `frame_done` pulses once.
- Loopback through the OV5640 capture block, `enable` held for 12 frames → from frame 11 on, captured `m_data` words equal the sent pixels in order, with 0 mismatches.
- `s_valid` low for pixel index 2 of line 0 → bytes 0x00, 0x00 at that slot; `underrun` pulses once; `href` width unchanged at 2*IMG_WIDTH.
- `enable` dropped during line 1 → frame completes with IMG_HEIGHT lines; one `frame_done`; stays IDLE with `vsync`=0.
- `rst` asserted mid-ACTIVE → next cycle all outputs 0; on re-enable, the first `vsync` is high for exactly VSYNC_CYC cycles.
- Handshake count over one 640x480 frame → 307200 `s_ready`-cycles; `vsync`/`href` overlap never occurs.
